// File: rtl/ecc_pkg.sv
// Shared types and widths for the ECC scrub controller and its request queue.
package ecc_pkg;

    localparam int ECC_DATA_W     = 16;
    localparam int ECC_SYN_W      = 6;
    // Queue entries carry addresses up to this width; narrower buses are zero-extended.
    localparam int ECC_ADDR_W_MAX = 32;

    typedef struct packed {
        logic [ECC_ADDR_W_MAX-1:0] addr;
        logic [ECC_DATA_W-1:0]     data;
    } scrub_req_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_CE   = 2'd1,
        ERR_UE   = 2'd2
    } err_class_t;

    // An uncorrectable flag always dominates, even if the decoder also reports a correction.
    function automatic err_class_t classify(input logic ce, input logic ue);
        if (ue) begin
            return ERR_UE;
        end
        if (ce) begin
            return ERR_CE;
        end
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/ecc_scrub_ctrl_if.sv
// Decoded-word input stream and scrub write-back request stream.
interface ecc_scrub_ctrl_if #(
    parameter int ADDR_W = 16
);
    import ecc_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_W-1:0]     in_addr;
    logic [ECC_DATA_W-1:0] in_data;
    logic                  in_ce;
    logic                  in_ue;
    logic [ECC_SYN_W-1:0]  in_syndrome;

    logic                  scrub_valid;
    logic                  scrub_ready;
    logic [ADDR_W-1:0]     scrub_addr;
    logic [ECC_DATA_W-1:0] scrub_data;

    modport master (
        output in_valid, in_addr, in_data, in_ce, in_ue, in_syndrome, scrub_ready,
        input  in_ready, scrub_valid, scrub_addr, scrub_data
    );

    modport slave (
        input  in_valid, in_addr, in_data, in_ce, in_ue, in_syndrome, scrub_ready,
        output in_ready, scrub_valid, scrub_addr, scrub_data
    );

endinterface

// File: rtl/ecc_scrub_fifo.sv
// Synchronous queue of scrub requests; pointers carry an extra wrap bit to tell full from empty.
module ecc_scrub_fifo
    import ecc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  scrub_req_t push_req,
    input  logic       pop,
    output scrub_req_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    scrub_req_t  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Storage is cleared on reset so the head outputs read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_req;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Post-decoder error handler: queues scrub write-backs for corrected words, counts CE/UE
// events with saturation, keeps a sticky first-error log and drives a level interrupt.
module ecc_scrub_ctrl
    import ecc_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CE_THRESH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ecc_scrub_ctrl_if.slave      bus,
    output logic [CNT_W-1:0]     ce_count,
    output logic [CNT_W-1:0]     ue_count,
    input  logic                 cnt_clear,
    output logic                 log_valid,
    output logic [ADDR_W-1:0]    log_addr,
    output logic [ECC_SYN_W-1:0] log_syn,
    output logic                 log_ue,
    input  logic                 log_clear,
    output logic                 irq
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CE_THR_CV = CNT_W'(CE_THRESH);

    err_class_t err_class;
    logic       fifo_full;
    logic       fifo_empty;
    logic       accept;
    logic       ce_evt;
    logic       ue_evt;
    logic       err_evt;
    logic       pop;
    scrub_req_t push_req;
    scrub_req_t head_req;

    assign err_class = classify(bus.in_ce, bus.in_ue);
    // Clean words are also back-pressured when full, keeping the stream strictly in order.
    assign accept    = bus.in_valid && !fifo_full;
    assign ce_evt    = accept && (err_class == ERR_CE);
    assign ue_evt    = accept && (err_class == ERR_UE);
    assign err_evt   = ce_evt || ue_evt;
    assign pop       = !fifo_empty && bus.scrub_ready;

    assign push_req.addr = ECC_ADDR_W_MAX'(bus.in_addr);
    assign push_req.data = bus.in_data;

    assign bus.in_ready    = !fifo_full;
    assign bus.scrub_valid = !fifo_empty;
    assign bus.scrub_addr  = ADDR_W'(head_req.addr);
    assign bus.scrub_data  = head_req.data;

    ecc_scrub_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (ce_evt),
        .push_req (push_req),
        .pop      (pop),
        .head     (head_req),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // A clear in the same cycle as an event leaves that event counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_count <= '0;
            ue_count <= '0;
        end else if (cnt_clear) begin
            ce_count <= ce_evt ? CNT_ONE : '0;
            ue_count <= ue_evt ? CNT_ONE : '0;
        end else begin
            if (ce_evt && (ce_count != CNT_MAX)) begin
                ce_count <= ce_count + CNT_ONE;
            end
            if (ue_evt && (ue_count != CNT_MAX)) begin
                ue_count <= ue_count + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            log_valid <= 1'b0;
            log_addr  <= '0;
            log_syn   <= '0;
            log_ue    <= 1'b0;
        end else if (err_evt && (!log_valid || log_clear)) begin
            log_valid <= 1'b1;
            log_addr  <= bus.in_addr;
            log_syn   <= bus.in_syndrome;
            log_ue    <= ue_evt;
        end else if (log_clear) begin
            log_valid <= 1'b0;
            log_addr  <= '0;
            log_syn   <= '0;
            log_ue    <= 1'b0;
        end
    end

    assign irq = (ce_count >= CE_THR_CV) || (ue_count != '0);

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl: scoreboarded scrub stream plus counter, log and irq checks.
module tb_ecc_scrub_ctrl;
    import ecc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ecc_scrub_ctrl_if #(.ADDR_W(16)) bus ();
    ecc_scrub_ctrl_if #(.ADDR_W(16)) bus4 ();

    logic [7:0]  ce_count, ue_count;
    logic        cnt_clear, log_clear;
    logic        log_valid, log_ue, irq;
    logic [15:0] log_addr;
    logic [5:0]  log_syn;

    logic [3:0]  ce_count4, ue_count4;
    logic        cnt_clear4, log_clear4;
    logic        log_valid4, log_ue4, irq4;
    logic [15:0] log_addr4;
    logic [5:0]  log_syn4;

    ecc_scrub_ctrl #(.ADDR_W(16), .CNT_W(8), .FIFO_DEPTH(4), .CE_THRESH(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ce_count(ce_count), .ue_count(ue_count), .cnt_clear(cnt_clear),
        .log_valid(log_valid), .log_addr(log_addr), .log_syn(log_syn), .log_ue(log_ue),
        .log_clear(log_clear), .irq(irq)
    );

    ecc_scrub_ctrl #(.ADDR_W(16), .CNT_W(4), .FIFO_DEPTH(4), .CE_THRESH(15)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4),
        .ce_count(ce_count4), .ue_count(ue_count4), .cnt_clear(cnt_clear4),
        .log_valid(log_valid4), .log_addr(log_addr4), .log_syn(log_syn4), .log_ue(log_ue4),
        .log_clear(log_clear4), .irq(irq4)
    );

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   acc_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe handshakes mid-cycle, then advance past the next rising edge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        acc_seen = bus.in_valid && bus.in_ready;
        if (bus.scrub_valid && bus.scrub_ready) begin
            n_checks++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected_pop observed_addr=%0h expected=none", bus.scrub_addr);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_addr", bus.scrub_addr, e.addr);
                check("sb_data", bus.scrub_data, e.data);
            end
        end
        if (acc_seen && bus.in_ce && !bus.in_ue) begin
            sb.push_back('{bus.in_addr, bus.in_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] d,
                         input logic ce, input logic ue, input logic [5:0] syn);
        bus.in_valid    = v;
        bus.in_addr     = a;
        bus.in_data     = d;
        bus.in_ce       = ce;
        bus.in_ue       = ue;
        bus.in_syndrome = syn;
    endtask

    task automatic drain();
        int k;
        bus.scrub_ready = 1'b1;
        k = 0;
        while (bus.scrub_valid && k < 50) begin
            cyc();
            k++;
        end
        check("drain_done", bus.scrub_valid, 1'b0);
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 6'h0);
        bus.scrub_ready  = 1'b0;
        cnt_clear = 1'b0; log_clear = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_addr = '0; bus4.in_data = '0;
        bus4.in_ce = 1'b0; bus4.in_ue = 1'b0; bus4.in_syndrome = '0;
        bus4.scrub_ready = 1'b1;
        cnt_clear4 = 1'b0; log_clear4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();

        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_scrub_valid", bus.scrub_valid, 1'b0);
        check("rst_ce", ce_count, 0);
        check("rst_ue", ue_count, 0);
        check("rst_log_valid", log_valid, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_irq4", irq4, 1'b0);

        // Single CE
        drive(1'b1, 16'h0040, 16'hBEEF, 1'b1, 1'b0, 6'h25);
        cyc();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 6'h0);
        check("ce1_scrub_valid", bus.scrub_valid, 1'b1);
        check("ce1_scrub_addr", bus.scrub_addr, 16'h0040);
        check("ce1_scrub_data", bus.scrub_data, 16'hBEEF);
        check("ce1_ce", ce_count, 1);
        check("ce1_log_valid", log_valid, 1'b1);
        check("ce1_log_addr", log_addr, 16'h0040);
        check("ce1_log_syn", log_syn, 6'h25);
        check("ce1_log_ue", log_ue, 1'b0);
        check("ce1_irq", irq, 1'b0);
        cyc();
        check("ce1_hold_addr", bus.scrub_addr, 16'h0040);
        drain();

        // Back-pressure: fill queue while memory port stalls
        cnt_clear = 1'b1;
        cyc();
        cnt_clear = 1'b0;
        check("clr_ce", ce_count, 0);
        bus.scrub_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h1000 + 16'(i), 16'hA000 + 16'(i), 1'b1, 1'b0, 6'h01);
            cyc();
            check("fill_accept", acc_seen, 1'b1);
        end
        drive(1'b1, 16'h1004, 16'hA004, 1'b1, 1'b0, 6'h01);
        check("full_in_ready", bus.in_ready, 1'b0);
        check("full_head", bus.scrub_addr, 16'h1000);
        check("full_ce", ce_count, 4);
        cyc();
        check("full_stall_accept", acc_seen, 1'b0);
        check("full_stall_ready", bus.in_ready, 1'b0);
        bus.scrub_ready = 1'b1;
        k = 0;
        do begin
            cyc();
            k++;
        end while (!acc_seen && k < 20);
        check("fifth_accepted", acc_seen, 1'b1);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 6'h0);
        drain();
        check("fill_ce5", ce_count, 5);

        // UE path, with a prior log clear
        log_clear = 1'b1;
        cyc();
        log_clear = 1'b0;
        check("lclr_valid", log_valid, 1'b0);
        check("lclr_addr", log_addr, 16'h0);
        check("lclr_syn", log_syn, 6'h0);
        drive(1'b1, 16'h0100, 16'h1234, 1'b1, 1'b1, 6'h3F);
        check("ue_irq_before", irq, 1'b0);
        cyc();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 6'h0);
        check("ue_no_scrub", bus.scrub_valid, 1'b0);
        check("ue_ue", ue_count, 1);
        check("ue_ce", ce_count, 5);
        check("ue_log_ue", log_ue, 1'b1);
        check("ue_log_addr", log_addr, 16'h0100);
        check("ue_log_syn", log_syn, 6'h3F);
        check("ue_irq", irq, 1'b1);

        // Clear coincident with a CE: CE counts as 1, UE goes to 0
        cnt_clear = 1'b1;
        drive(1'b1, 16'h0300, 16'h5555, 1'b1, 1'b0, 6'h07);
        cyc();
        cnt_clear = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 6'h0);
        check("cclr_ce", ce_count, 1);
        check("cclr_ue", ue_count, 0);
        check("cclr_irq", irq, 1'b0);
        check("log_sticky_addr", log_addr, 16'h0100);
        drain();

        // Clean word changes nothing
        drive(1'b1, 16'h0400, 16'h7777, 1'b0, 1'b0, 6'h00);
        cyc();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 6'h0);
        check("clean_accept", acc_seen, 1'b1);
        check("clean_ce", ce_count, 1);
        check("clean_ue", ue_count, 0);
        check("clean_scrub", bus.scrub_valid, 1'b0);
        check("clean_log_addr", log_addr, 16'h0100);

        // Log clear coincident with a new CE
        log_clear = 1'b1;
        drive(1'b1, 16'h0200, 16'h2222, 1'b1, 1'b0, 6'h11);
        cyc();
        log_clear = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 6'h0);
        check("lce_valid", log_valid, 1'b1);
        check("lce_addr", log_addr, 16'h0200);
        check("lce_syn", log_syn, 6'h11);
        check("lce_ue", log_ue, 1'b0);
        drain();

        // Reset in the middle of traffic
        bus.scrub_ready = 1'b0;
        drive(1'b1, 16'h0500, 16'h0A0A, 1'b1, 1'b0, 6'h02);
        cyc();
        drive(1'b1, 16'h0501, 16'h0B0B, 1'b0, 1'b1, 6'h03);
        cyc();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 6'h0);
        check("pre_rst_valid", bus.scrub_valid, 1'b1);
        check("pre_rst_irq", irq, 1'b1);
        rst = 1'b1;
        #1;
        check("mrst_in_ready", bus.in_ready, 1'b1);
        check("mrst_scrub_valid", bus.scrub_valid, 1'b0);
        check("mrst_ce", ce_count, 0);
        check("mrst_ue", ue_count, 0);
        check("mrst_log_valid", log_valid, 1'b0);
        check("mrst_irq", irq, 1'b0);
        sb.delete();
        cyc();
        rst = 1'b0;
        bus.scrub_ready = 1'b1;
        cyc();
        check("no_replay", bus.scrub_valid, 1'b0);

        // Saturation on the narrow-counter instance
        for (int i = 0; i < 20; i++) begin
            check("sat_ce4", ce_count4, (i < 15) ? i : 15);
            check("sat_irq4", irq4, (i >= 15) ? 1'b1 : 1'b0);
            check("sat_ready4", bus4.in_ready, 1'b1);
            bus4.in_valid = 1'b1;
            bus4.in_addr  = 16'h2000 + 16'(i);
            bus4.in_data  = 16'hC000 + 16'(i);
            bus4.in_ce    = 1'b1;
            cyc();
        end
        bus4.in_valid = 1'b0;
        bus4.in_ce    = 1'b0;
        check("sat_final_ce4", ce_count4, 15);
        check("sat_final_irq4", irq4, 1'b1);
        cyc();
        check("sat_hold_irq4", irq4, 1'b1);
        check("sat_hold_ue4", ue_count4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
